// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared definitions for the command sequencer: frame opcodes, the RF slots
// that receive ALU operands, and the sequencer state encoding.
package sys_cmd_ctrl_pkg;

    localparam logic [7:0] OPC_WR      = 8'hAA;
    localparam logic [7:0] OPC_RD      = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_ALU_FN,
        ST_ALU_WAIT,
        ST_TX_LSB,
        ST_TX_MSB,
        ST_TX_RD
    } state_t;

    // The ALU clock runs from the first operand byte until its result is back.
    function automatic logic clk_gate_on(input state_t s);
        return (s == ST_OP_A) || (s == ST_OP_B) || (s == ST_ALU_FN) || (s == ST_ALU_WAIT);
    endfunction

endpackage

// File: rtl/sys_cmd_ctrl.sv
// Command sequencer: parses RX command frames, drives RF / ALU strobes, pushes responses to TX FIFO.
// Strobes appear one cycle after the triggering byte or valid pulse; TX pushes stall while FIFO_FULL.
module sys_cmd_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FUN_W  = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [DATA_W-1:0]   RX_P_DATA,
    input  logic                RX_D_VLD,
    input  logic [DATA_W-1:0]   RF_RdData,
    input  logic                RF_RdData_VLD,
    input  logic [2*DATA_W-1:0] ALU_OUT,
    input  logic                ALU_OUT_VLD,
    input  logic                FIFO_FULL,
    output logic [ADDR_W-1:0]   RF_Address,
    output logic                RF_WrEn,
    output logic                RF_RdEn,
    output logic [DATA_W-1:0]   RF_WrData,
    output logic                ALU_EN,
    output logic [FUN_W-1:0]    ALU_FUN,
    output logic                CLK_GATE_EN,
    output logic [DATA_W-1:0]   WR_DATA,
    output logic                WR_INC
);
    import sys_cmd_ctrl_pkg::*;

    state_t              state_q,       state_d;
    logic [ADDR_W-1:0]   rf_address_q,  rf_address_d;
    logic                rf_wren_q,     rf_wren_d;
    logic                rf_rden_q,     rf_rden_d;
    logic [DATA_W-1:0]   rf_wrdata_q,   rf_wrdata_d;
    logic                alu_en_q,      alu_en_d;
    logic [FUN_W-1:0]    alu_fun_q,     alu_fun_d;
    logic                clk_gate_en_q, clk_gate_en_d;
    logic [DATA_W-1:0]   wr_data_q,     wr_data_d;
    logic                wr_inc_q,      wr_inc_d;
    // Holds either the 16-bit ALU result or the zero-extended RF read byte.
    logic [2*DATA_W-1:0] result_q,      result_d;

    always_comb begin
        state_d       = state_q;
        rf_address_d  = rf_address_q;
        rf_wren_d     = 1'b0;
        rf_rden_d     = 1'b0;
        rf_wrdata_d   = rf_wrdata_q;
        alu_en_d      = 1'b0;
        alu_fun_d     = alu_fun_q;
        wr_data_d     = wr_data_q;
        wr_inc_d      = 1'b0;
        result_d      = result_q;

        case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == DATA_W'(OPC_WR))           state_d = ST_WR_ADDR;
                    else if (RX_P_DATA == DATA_W'(OPC_RD))      state_d = ST_RD_ADDR;
                    else if (RX_P_DATA == DATA_W'(OPC_ALU_OP))  state_d = ST_OP_A;
                    else if (RX_P_DATA == DATA_W'(OPC_ALU_NOP)) state_d = ST_ALU_FN;
                end
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    rf_address_d = RX_P_DATA[ADDR_W-1:0];
                    state_d      = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wrdata_d = RX_P_DATA;
                    rf_wren_d   = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_address_d = RX_P_DATA[ADDR_W-1:0];
                    rf_rden_d    = 1'b1;
                    state_d      = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (RF_RdData_VLD) begin
                    result_d = {{DATA_W{1'b0}}, RF_RdData};
                    state_d  = ST_TX_RD;
                end
            end
            ST_OP_A: begin
                if (RX_D_VLD) begin
                    rf_address_d = ADDR_W'(OPA_ADDR);
                    rf_wrdata_d  = RX_P_DATA;
                    rf_wren_d    = 1'b1;
                    state_d      = ST_OP_B;
                end
            end
            ST_OP_B: begin
                if (RX_D_VLD) begin
                    rf_address_d = ADDR_W'(OPB_ADDR);
                    rf_wrdata_d  = RX_P_DATA;
                    rf_wren_d    = 1'b1;
                    state_d      = ST_ALU_FN;
                end
            end
            ST_ALU_FN: begin
                if (RX_D_VLD) begin
                    alu_fun_d = RX_P_DATA[FUN_W-1:0];
                    alu_en_d  = 1'b1;
                    state_d   = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    result_d = ALU_OUT;
                    state_d  = ST_TX_LSB;
                end
            end
            ST_TX_LSB: begin
                if (!FIFO_FULL) begin
                    wr_data_d = result_q[DATA_W-1:0];
                    wr_inc_d  = 1'b1;
                    state_d   = ST_TX_MSB;
                end
            end
            ST_TX_MSB: begin
                if (!FIFO_FULL) begin
                    wr_data_d = result_q[2*DATA_W-1:DATA_W];
                    wr_inc_d  = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_TX_RD: begin
                if (!FIFO_FULL) begin
                    wr_data_d = result_q[DATA_W-1:0];
                    wr_inc_d  = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered from the next state so the gate tracks the state exactly.
        clk_gate_en_d = clk_gate_on(state_d);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            rf_address_q  <= '0;
            rf_wren_q     <= 1'b0;
            rf_rden_q     <= 1'b0;
            rf_wrdata_q   <= '0;
            alu_en_q      <= 1'b0;
            alu_fun_q     <= '0;
            clk_gate_en_q <= 1'b0;
            wr_data_q     <= '0;
            wr_inc_q      <= 1'b0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            rf_address_q  <= rf_address_d;
            rf_wren_q     <= rf_wren_d;
            rf_rden_q     <= rf_rden_d;
            rf_wrdata_q   <= rf_wrdata_d;
            alu_en_q      <= alu_en_d;
            alu_fun_q     <= alu_fun_d;
            clk_gate_en_q <= clk_gate_en_d;
            wr_data_q     <= wr_data_d;
            wr_inc_q      <= wr_inc_d;
            result_q      <= result_d;
        end
    end

    assign RF_Address  = rf_address_q;
    assign RF_WrEn     = rf_wren_q;
    assign RF_RdEn     = rf_rden_q;
    assign RF_WrData   = rf_wrdata_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_GATE_EN = clk_gate_en_q;
    assign WR_DATA     = wr_data_q;
    assign WR_INC      = wr_inc_q;

endmodule

// File: doc/sys_cmd_ctrl.md
# sys_cmd_ctrl

Command sequencer in the system clock domain, sitting directly behind the RX byte synchronizer. It consumes the synchronized byte stream and its one-cycle valid pulse, parses fixed-format command frames, and drives the register file, the ALU and its clock gate. It pushes response bytes into the TX async FIFO, honouring FIFO back-pressure.

## Interface
Parameters:
- DATA_W, 8, RX/TX byte width and register-file data width
- ADDR_W, 4, register-file address width
- FUN_W, 4, ALU function-select width

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  DATA_W  synchronized RX byte
- RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA is valid this cycle
- RF_RdData  in  DATA_W  register-file read data
- RF_RdData_VLD  in  1  register-file read data valid pulse
- ALU_OUT  in  2*DATA_W  ALU result
- ALU_OUT_VLD  in  1  ALU result valid pulse
- FIFO_FULL  in  1  TX FIFO full
- RF_Address  out  ADDR_W  register-file address
- RF_WrEn  out  1  register-file write strobe
- RF_RdEn  out  1  register-file read strobe
- RF_WrData  out  DATA_W  register-file write data
- ALU_EN  out  1  ALU operation strobe
- ALU_FUN  out  FUN_W  ALU function select
- CLK_GATE_EN  out  1  ALU clock-gate enable
- WR_DATA  out  DATA_W  TX FIFO write data
- WR_INC  out  1  TX FIFO push strobe

## Operation
- Frames start with an opcode byte accepted in IDLE:
  - 0xAA: write; then addr, then data
  - 0xBB: read; then addr
  - 0xCC: ALU with operands; then A, B, fun
  - 0xDD: ALU without operands; then fun
- Any other byte received in IDLE is dropped and the FSM stays in IDLE.
- Address bytes use bits [ADDR_W-1:0]; the upper bits are ignored.
- States and transitions:
  - IDLE → WR_ADDR / RD_ADDR / OP_A / ALU_FN, according to the opcode.
  - WR_ADDR → WR_DATA: latch the address.
  - WR_DATA → IDLE: issue the RF write.
  - RD_ADDR → RD_WAIT: issue the RF read.
  - RD_WAIT → TX_RD on RF_RdData_VLD: capture RF_RdData.
  - OP_A → OP_B: write the byte to RF address 0.
  - OP_B → ALU_FN: write the byte to RF address 1.
  - ALU_FN → ALU_WAIT: pulse ALU_EN with ALU_FUN = byte[FUN_W-1:0].
  - ALU_WAIT → TX_LSB on ALU_OUT_VLD: capture the 16-bit result.
  - TX_LSB → TX_MSB, TX_MSB → IDLE, TX_RD → IDLE.
- Parsing states (WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FN) advance only on RX_D_VLD.
- RX_D_VLD arriving in RD_WAIT, ALU_WAIT or any TX state is dropped.
- TX states push one byte when FIFO_FULL = 0, then advance.
  - While FIFO_FULL = 1, WR_INC stays 0 and the state holds.
  - The result order is LSB then MSB; a read response is one byte.
- CLK_GATE_EN = 1 in OP_A, OP_B, ALU_FN and ALU_WAIT; 0 elsewhere.

## Timing
- All outputs are registered.
- Reset values: RF_Address, RF_WrData, WR_DATA, ALU_FUN = 0; RF_WrEn, RF_RdEn, ALU_EN, WR_INC, CLK_GATE_EN = 0; state = IDLE.
- RF_WrEn, RF_RdEn, ALU_EN and WR_INC are single-cycle pulses, asserted in the cycle after the triggering RX_D_VLD or valid pulse.
- RF_Address and RF_WrData are stable during RF_WrEn and RF_RdEn.
- WR_INC is asserted in the cycle after FIFO_FULL = 0 is sampled in a TX state.
- FIFO_FULL rising in the same cycle as a sampled-free slot does not cancel that push.
- Back-to-back frames: an opcode byte arriving the cycle after a frame returns to IDLE is accepted.
- RST asserted mid-frame: asynchronous return to IDLE; all strobes drop immediately; the partial frame is discarded.
- A valid pulse arriving while not in the matching wait state is ignored.

## Structure
- Shared package: opcode constants (0xAA, 0xBB, 0xCC, 0xDD), operand RF addresses (0, 1) and the state enumeration.
- Single module with no sub-modules.
- The TX push logic stays inline as FSM states.

## Test plan
- Write: send 0xAA, 0x05, 0x3C → one RF_WrEn pulse with RF_Address = 5, RF_WrData = 0x3C; no WR_INC.
- Read: send 0xBB, 0x05; return RF_RdData = 0x3C with VLD after 3 cycles → RF_RdEn with addr 5, then WR_INC with WR_DATA = 0x3C.
- ALU with operands: send 0xCC, 0x0A, 0x03, 0x02 → RF writes addr0 = 0x0A and addr1 = 0x03, ALU_EN with ALU_FUN = 2, CLK_GATE_EN high until the result.
  - Return ALU_OUT = 0x001E → pushes 0x1E then 0x00.
- Back-pressure: hold FIFO_FULL = 1 during 0xDD, 0x00 with result 0x1234 → no WR_INC.
  - Release FIFO_FULL → pushes 0x34, then 0x12, each exactly once.
- Junk and reset: send 0x55 in IDLE → no strobes.
  - Assert RST after 0xAA, 0x02 → state IDLE, outputs at reset values.
  - Next frame 0xAA, 0x01, 0xFF → writes addr 1 = 0xFF.
